// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, reset PC,
// NOP encoding and fetch state encodings.
package inst_fetch_pkg;

    localparam int          WORDSIZE         = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    localparam logic [0:0]  FETCH_RUN        = 1'b0;
    localparam logic [0:0]  FETCH_HALT       = 1'b1;

    // Instruction addresses must be word aligned.
    function automatic logic isAligned(input logic [1:0] lowBits);
        return lowBits == 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Small synchronous FIFO holding {pc, inst} pairs between fetch and decode.
// Flush empties the queue in one cycle; push and pop together on a full queue is legal.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULLCOUNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [PW:0]      count;
    logic             doPush;
    logic             doPop;

    assign full   = (count == FULLCOUNT);
    assign empty  = (count == '0);
    assign doPush = push & (~full | pop);
    assign doPop  = pop & ~empty;

    // Decode sees zeros rather than stale storage while nothing is queued.
    assign rdata  = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            count <= count + {{PW{1'b0}}, doPush} - {{PW{1'b0}}, doPop};
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !flush) mem[wrPtr] <= wdata;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, addresses the ROM, queues fetched
// {pc, inst} pairs for decode and handles redirects from execute.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = inst_fetch_pkg::RESET_PC_DEFAULT,
    parameter int          QDEPTH   = 2,
    parameter int          WORDSIZE = inst_fetch_pkg::WORDSIZE
) (
    input  logic                clk,
    input  logic                reset,
    output logic [WORDSIZE-1:0] imem_addr,
    input  logic [WORDSIZE-1:0] imem_data,
    input  logic                redirect_valid,
    input  logic [WORDSIZE-1:0] redirect_pc,
    output logic                out_valid,
    output logic [WORDSIZE-1:0] out_inst,
    output logic [WORDSIZE-1:0] out_pc,
    input  logic                out_ready,
    output logic                misalign_err
);

    logic [WORDSIZE-1:0]   pc;
    logic [0:0]            state;
    logic                  isRun;
    logic                  redirectTaken;
    logic                  redirectOk;
    logic                  redirectBad;
    logic                  pop;
    logic                  push;
    logic                  qFull;
    logic                  qEmpty;
    logic [2*WORDSIZE-1:0] qHead;

    assign imem_addr     = pc;
    assign isRun         = (state == FETCH_RUN);
    assign redirectTaken = isRun & redirect_valid;
    assign redirectOk    = redirectTaken & isAligned(redirect_pc[1:0]);
    assign redirectBad   = redirectTaken & ~isAligned(redirect_pc[1:0]);

    // A redirect flushes the queue, so it overrides any same-cycle fetch.
    assign pop           = out_valid & out_ready;
    assign push          = isRun & ~redirectTaken & (~qFull | pop);

    assign out_valid     = ~qEmpty;
    assign out_pc        = qHead[2*WORDSIZE-1:WORDSIZE];
    assign out_inst      = qHead[WORDSIZE-1:0];

    fetch_queue #(
        .WIDTH (2 * WORDSIZE),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .flush (redirectTaken),
        .push  (push),
        .pop   (pop),
        .wdata ({pc, imem_data}),
        .rdata (qHead),
        .full  (qFull),
        .empty (qEmpty)
    );

    // HALT is only left through reset; a misaligned target leaves the PC untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= RESET_PC[WORDSIZE-1:0];
            state        <= FETCH_RUN;
            misalign_err <= 1'b0;
        end else if (redirectOk) begin
            pc <= redirect_pc;
        end else if (redirectBad) begin
            state        <= FETCH_HALT;
            misalign_err <= 1'b1;
        end else if (push) begin
            pc <= pc + WORDSIZE'(4);
        end
    end

endmodule
